// File: rtl/apes_pkg.sv
// Shared types and constants for the APES readout sequencers.
package apes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_XFER      = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

    localparam logic SEL_SCI = 1'b0;
    localparam logic SEL_HK  = 1'b1;

    // 1 ms at 50 MHz
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 50000;

endpackage

// File: rtl/apes_wdog.sv
// Timeout counter: cleared by clr, advanced by en, expired when the count reaches limit.
module apes_wdog #(
    parameter int unsigned TO_W = 16
) (
    input  logic            clk50,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk50) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_W'(1);
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/apes_rdout_arb.sv
// Arbitrates the rocket telemetry serializer between science readout and housekeeping,
// with starvation protection for housekeeping and a per-phase watchdog.
module apes_rdout_arb
    import apes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int unsigned TO_W        = 16,
    parameter int unsigned HK_MAX_WAIT = 4
) (
    input  logic clk50,
    input  logic rst,
    input  logic sci_req,
    input  logic hk_req,
    input  logic ser_busy,
    input  logic err_clr,
    output logic ser_start,
    output logic ser_sel,
    output logic sci_gnt,
    output logic hk_gnt,
    output logic sci_done,
    output logic hk_done,
    output logic timeout_err
);

    localparam int unsigned     SW         = (HK_MAX_WAIT < 1) ? 1 : $clog2(HK_MAX_WAIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(HK_MAX_WAIT);
    localparam logic [TO_W-1:0] WD_LIMIT   = TO_W'(TIMEOUT_CYC - 1);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          sci_armed;
    logic          hk_armed;

    logic sci_elig;
    logic hk_elig;
    logic pick_hk;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;
    logic xfer_end;
    logic wd_trip;

    apes_wdog #(
        .TO_W (TO_W)
    ) u_wdog (
        .clk50   (clk50),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (WD_LIMIT),
        .expired (wd_expired)
    );

    always_comb begin
        sci_elig = sci_req & sci_armed;
        hk_elig  = hk_req & hk_armed;
        pick_hk  = hk_elig & (~sci_elig | (starve_cnt == STARVE_MAX));
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        xfer_end = 1'b0;
        wd_trip  = 1'b0;
        case (state)
            ST_START: wd_clr = 1'b1;
            ST_WAIT_BUSY: begin
                wd_clr   = ser_busy;
                wd_en    = ~ser_busy & ~wd_expired;
                wd_trip  = ~ser_busy & wd_expired;
                xfer_end = wd_trip;
            end
            ST_XFER: begin
                wd_en    = ser_busy & ~wd_expired;
                wd_trip  = ser_busy & wd_expired;
                xfer_end = ~ser_busy | wd_expired;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state       <= ST_IDLE;
            starve_cnt  <= '0;
            sci_armed   <= 1'b1;
            hk_armed    <= 1'b1;
            ser_start   <= 1'b0;
            ser_sel     <= SEL_SCI;
            sci_gnt     <= 1'b0;
            hk_gnt      <= 1'b0;
            sci_done    <= 1'b0;
            hk_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ser_start <= 1'b0;
            sci_done  <= 1'b0;
            hk_done   <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (sci_elig || hk_elig) begin
                        ser_sel   <= pick_hk ? SEL_HK : SEL_SCI;
                        sci_gnt   <= ~pick_hk;
                        hk_gnt    <= pick_hk;
                        ser_start <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (ser_busy) begin
                        state <= ST_XFER;
                    end
                end
                ST_XFER: ;
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (ser_sel == SEL_HK) begin
                        hk_armed   <= 1'b0;
                        starve_cnt <= '0;
                    end else begin
                        sci_armed <= 1'b0;
                        if (!hk_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Both normal completion and watchdog abort funnel into DONE with the owner's pulse
            if (xfer_end) begin
                state    <= ST_DONE;
                sci_gnt  <= 1'b0;
                hk_gnt   <= 1'b0;
                sci_done <= (ser_sel == SEL_SCI);
                hk_done  <= (ser_sel == SEL_HK);
            end
            if (wd_trip) begin
                timeout_err <= 1'b1;
            end

            // A dropped request re-arms; placed last so it overrides the DONE-time disarm
            if (!sci_req) begin
                sci_armed <= 1'b1;
            end
            if (!hk_req) begin
                hk_armed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apes_rdout_arb.sv
// Self-checking bench for apes_rdout_arb: cycle-level reference model plus directed scenarios.
module tb_apes_rdout_arb;

    localparam int TO  = 16;
    localparam int HKW = 4;

    logic clk50    = 1'b0;
    logic rst      = 1'b1;
    logic sci_req  = 1'b0;
    logic hk_req   = 1'b0;
    logic ser_busy = 1'b0;
    logic err_clr  = 1'b0;
    logic ser_start, ser_sel, sci_gnt, hk_gnt, sci_done, hk_done, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    apes_rdout_arb #(
        .TIMEOUT_CYC (TO),
        .TO_W        (16),
        .HK_MAX_WAIT (HKW)
    ) dut (
        .clk50       (clk50),
        .rst         (rst),
        .sci_req     (sci_req),
        .hk_req      (hk_req),
        .ser_busy    (ser_busy),
        .err_clr     (err_clr),
        .ser_start   (ser_start),
        .ser_sel     (ser_sel),
        .sci_gnt     (sci_gnt),
        .hk_gnt      (hk_gnt),
        .sci_done    (sci_done),
        .hk_done     (hk_done),
        .timeout_err (timeout_err)
    );

    always #10 clk50 = ~clk50;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chkv(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 start, 2 awaiting busy, 3 busy, 4 finishing
    int   ph, own, starve, wait_n;
    bit   sa, ha, chk_en;
    logic m_start, m_sel, m_sg, m_hg, m_sd, m_hd, m_err;

    initial chk_en = 1'b0;

    always @(posedge clk50) begin : model
        bit se, he, hkw, fin, tmo;
        if (rst) begin
            ph = 0; own = 0; starve = 0; wait_n = 0; sa = 1'b1; ha = 1'b1;
            m_start = 0; m_sel = 0; m_sg = 0; m_hg = 0; m_sd = 0; m_hd = 0; m_err = 0;
        end else begin
            fin = 1'b0;
            tmo = 1'b0;
            m_start = 0; m_sd = 0; m_hd = 0;
            if (err_clr) m_err = 0;
            case (ph)
                0: begin
                    se = sci_req && sa;
                    he = hk_req && ha;
                    if (se || he) begin
                        hkw     = he && (!se || starve == HKW);
                        own     = hkw ? 2 : 1;
                        m_sel   = hkw;
                        m_sg    = !hkw;
                        m_hg    = hkw;
                        m_start = 1;
                        ph      = 1;
                    end
                end
                1: begin ph = 2; wait_n = 0; end
                2: begin
                    wait_n++;
                    if (ser_busy) begin ph = 3; wait_n = 0; end
                    else if (wait_n == TO) begin fin = 1; tmo = 1; end
                end
                3: begin
                    wait_n++;
                    if (!ser_busy) fin = 1;
                    else if (wait_n == TO) begin fin = 1; tmo = 1; end
                end
                default: begin
                    if (own == 2) begin
                        ha = 0;
                        starve = 0;
                    end else begin
                        sa = 0;
                        starve = hk_req ? ((starve < HKW) ? starve + 1 : HKW) : 0;
                    end
                    ph = 0;
                    own = 0;
                end
            endcase
            if (fin) begin
                ph = 4; m_sg = 0; m_hg = 0;
                m_sd = (own == 1);
                m_hd = (own == 2);
                if (tmo) m_err = 1;
            end
            if (!sci_req) sa = 1;
            if (!hk_req) ha = 1;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk50) begin
        if (chk_en) begin
            n_cmp++;
            if ({ser_start, ser_sel, sci_gnt, hk_gnt, sci_done, hk_done, timeout_err} !==
                {m_start, m_sel, m_sg, m_hg, m_sd, m_hd, m_err}) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t: got start/sel/sg/hg/sd/hd/err=%b%b%b%b%b%b%b expected %b%b%b%b%b%b%b",
                         $time, ser_start, ser_sel, sci_gnt, hk_gnt, sci_done, hk_done, timeout_err,
                         m_start, m_sel, m_sg, m_hg, m_sd, m_hd, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic wait_grant(output int who);
        int n = 0;
        while (!ser_start && n < 10) begin
            tick();
            n++;
        end
        chk1("grant_seen", ser_start, 1'b1);
        who = hk_gnt ? 2 : (sci_gnt ? 1 : 0);
    endtask

    // Called in the START cycle; returns in the DONE cycle (or after the bound expires)
    task automatic serve(input int lat, input int len, output int who);
        int n = 0;
        who = hk_gnt ? 2 : 1;
        repeat (lat) tick();
        ser_busy = 1'b1;
        repeat (len) tick();
        ser_busy = 1'b0;
        while (!(sci_done || hk_done) && n < 20) begin
            tick();
            n++;
        end
        chk1("serve_done", (who == 1) ? sci_done : hk_done, 1'b1);
    endtask

    initial begin
        int who;
        int exp_order[11] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1};

        rst = 1'b1;
        repeat (2) tick();
        chkv("reset_outputs",
             int'({ser_start, ser_sel, sci_gnt, hk_gnt, sci_done, hk_done, timeout_err}), 0);
        rst = 1'b0;

        // Science only, busy on cycles 3..10; request held past done, dropped on 15
        sci_req = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk1("t1_start", ser_start, (k == 1 || k == 17));
            chk1("t1_sci_gnt", sci_gnt, ((k >= 1 && k <= 11) || k == 17));
            chk1("t1_sci_done", sci_done, (k == 12));
            chk1("t1_hk_done", hk_done, 1'b0);
            chk1("t1_sel", ser_sel, 1'b0);
            ser_busy = (k >= 3 && k <= 10);
            sci_req  = (k != 15);
        end
        sci_req = 1'b0;
        serve(1, 3, who);
        chkv("t1_second_owner", who, 1);
        repeat (2) tick();

        // Both requesting; each owner drops its request for its DONE cycle only
        sci_req = 1'b1;
        hk_req  = 1'b1;
        for (int g = 0; g < 11; g++) begin
            wait_grant(who);
            chkv("t2_grant_order", who, exp_order[g]);
            chk1("t2_sel", ser_sel, (exp_order[g] == 2));
            serve(1, 2, who);
            if (who == 1) sci_req = 1'b0;
            else hk_req = 1'b0;
            tick();
            sci_req = (g < 10);
            hk_req  = (g < 10);
        end
        repeat (3) tick();

        // Watchdog in WAIT_BUSY: busy never rises; request dropped mid-transfer
        sci_req = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            chk1("t3_start", ser_start, (k == 1));
            chk1("t3_sci_gnt", sci_gnt, (k <= 17));
            chk1("t3_sci_done", sci_done, (k == 18));
            chk1("t3_err", timeout_err, (k >= 18));
            if (k == 1) sci_req = 1'b0;
        end
        repeat (3) tick();
        chk1("t3_err_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk1("t3_err_cleared", timeout_err, 1'b0);
        repeat (2) tick();

        // Watchdog in XFER: busy stuck high; err_clr on the expiry cycle loses to the set
        hk_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk1("t4_hk_gnt", hk_gnt, (k <= 18));
            chk1("t4_hk_done", hk_done, (k == 19));
            chk1("t4_sci_done", sci_done, 1'b0);
            chk1("t4_err", timeout_err, (k >= 19));
            chk1("t4_sel", ser_sel, 1'b1);
            if (k == 1) hk_req = 1'b0;
            ser_busy = (k >= 2 && k <= 18);
            err_clr  = (k == 18);
        end
        ser_busy = 1'b0;
        err_clr  = 1'b0;
        tick();
        chk1("t4_sel_hold_idle", ser_sel, 1'b1);

        // Reset mid-XFER; busy already high during START is ignored
        sci_req = 1'b1;
        tick();
        chk1("t5_start", ser_start, 1'b1);
        chk1("t5_sel_on_grant", ser_sel, 1'b0);
        ser_busy = 1'b1;
        tick();
        tick();
        chk1("t5_in_xfer_gnt", sci_gnt, 1'b1);
        rst = 1'b1;
        tick();
        chkv("t5_reset_outputs",
             int'({ser_start, ser_sel, sci_gnt, hk_gnt, sci_done, hk_done, timeout_err}), 0);
        rst      = 1'b0;
        ser_busy = 1'b0;
        tick();
        chk1("t5_regrant", ser_start, 1'b1);
        chk1("t5_regrant_gnt", sci_gnt, 1'b1);
        sci_req = 1'b0;
        serve(1, 2, who);
        chkv("t5_owner", who, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench time limit");
    end

endmodule
